// File: rtl/zr_arty_pkg.sv
// Shared Arty A7 board constants and types for the input conditioning path.
package zr_arty_pkg;

  localparam int CLK_SYS_HZ  = 16_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Default qualification window: DEBOUNCE_MS worth of system clocks.
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_SYS_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic {
    DB_IDLE,
    DB_CONFIRM
  } db_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arty_debounce_bit.sv
// One conditioned input: synchronizer, debounce FSM with stability counter,
// and registered rise/fall/change pulses aligned with the debounced level.
module arty_debounce_bit
  import zr_arty_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic in_db,
  output logic rise,
  output logic fall,
  output logic change
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("arty_debounce_bit: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("arty_debounce_bit: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;

  // Synchronizer chain; only the last stage feeds the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM: accept a new level only after DEBOUNCE_CYCLES consecutive
  // samples that differ from in_db; any agreeing sample restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      in_db   <= RESET_VALUE;
      rise    <= 1'b0;
      fall    <= 1'b0;
      change  <= 1'b0;
    end else begin
      rise   <= 1'b0;
      fall   <= 1'b0;
      change <= 1'b0;
      case (state_q)
        DB_IDLE: begin
          if (s != in_db) begin
            state_q <= DB_CONFIRM;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        DB_CONFIRM: begin
          if (s == in_db) begin
            // Glitch: input returned to the accepted level.
            state_q <= DB_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            in_db   <= s;
            rise    <= s;
            fall    <= ~s;
            change  <= 1'b1;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/arty_input_debounce.sv
// Conditions the bouncing Arty A7 buttons and switches for the SoC GPIO input:
// per-bit synchronize, debounce and edge-detect, plus an aggregate change flag.
module arty_input_debounce
  import zr_arty_pkg::*;
#(
  parameter int                  N_INPUTS        = 8,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [N_INPUTS-1:0] RESET_VALUE     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] in_raw,
  output logic [N_INPUTS-1:0] in_db,
  output logic [N_INPUTS-1:0] rise_o,
  output logic [N_INPUTS-1:0] fall_o,
  output logic                change_o
);

  logic [N_INPUTS-1:0] change_bit;

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_bit
    arty_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE    (RESET_VALUE[i])
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .in_raw(in_raw[i]),
      .in_db (in_db[i]),
      .rise  (rise_o[i]),
      .fall  (fall_o[i]),
      .change(change_bit[i])
    );
  end

  // Each bit's change flag is already registered with its pulses.
  assign change_o = |change_bit;

endmodule
